input_skew_feeder: RTL



---
 rtl/neurex_pkg.sv | 20 ++
 rtl/input_skew_feeder_skew_lane.sv | 35 +++
 rtl/input_skew_feeder.sv | 112 +++++++++++
 3 files changed

// File: rtl/neurex_pkg.sv
// Shared types for the input operand path: lane element, lane slot and feeder FSM states.
package neurex_pkg;

  localparam int LANE_DATA_WIDTH = 16;

  typedef logic [LANE_DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    logic  valid;
    data_t data;
  } lane_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/input_skew_feeder_skew_lane.sv
// DEPTH-stage {valid, data} delay line with a common hold; DEPTH=0 is a plain wire.
module skew_lane #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, hold};
    assign out_valid   = in_valid;
    assign out_data    = in_data;
  end else begin : g_chain
    logic [DATA_WIDTH:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (!hold) begin
        stage[0] <= {in_valid, in_data};
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign {out_valid, out_data} = stage[DEPTH-1];
  end

endmodule

// File: rtl/input_skew_feeder.sv
// Skews input-memory row vectors into a diagonal wavefront for the systolic array
// and signals the end of each tile once the last element leaves the last lane.
//
// state  | meaning
// IDLE   | waiting for the first vector of a tile
// STREAM | accepting vectors; non-accept cycles inject bubbles
// DRAIN  | last vector taken, flushing the skew stages (cnt tracks progress)
// DONE   | last element on lane SYS_ROW-1, done asserted
module input_skew_feeder
  import neurex_pkg::*;
#(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = $clog2(SYS_ROW) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data [SYS_ROW],
  output logic                  in_ready,
  input  logic                  stall,
  output logic [SYS_ROW-1:0]    out_valid,
  output logic [DATA_WIDTH-1:0] out_data [SYS_ROW],
  output logic                  busy,
  output logic                  done
);

  localparam int MAX_CNT  = SYS_ROW - 1;
  localparam int LAST_CNT = (SYS_ROW > 1) ? SYS_ROW - 2 : 0;

  feeder_state_t         state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  accept;
  logic [SYS_ROW-1:0]    lane_valid;
  logic [DATA_WIDTH-1:0] lane_data [SYS_ROW];

  assign in_ready = !stall && (state == IDLE || state == STREAM);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Non-accept cycles push a zero bubble so gaps skew along with the data.
  for (genvar r = 0; r < SYS_ROW; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_in;
    assign lane_in = accept ? in_data[r] : '0;

    skew_lane #(
      .DEPTH      (r),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .hold      (stall),
      .in_valid  (accept),
      .in_data   (lane_in),
      .out_valid (lane_valid[r]),
      .out_data  (lane_data[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      for (int r = 0; r < SYS_ROW; r++) out_data[r] <= '0;
    end else if (!stall) begin
      out_valid <= lane_valid;
      for (int r = 0; r < SYS_ROW; r++) out_data[r] <= lane_data[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!stall) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // DRAIN leaves one cycle before cnt would hit MAX_CNT so DONE lines up with lane SYS_ROW-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, STREAM: begin
        if (accept) begin
          if (!in_last) begin
            state_nxt = STREAM;
          end else if (SYS_ROW == 1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end
        end
      end
      DRAIN: begin
        if (cnt != CNT_WIDTH'(MAX_CNT)) cnt_nxt = cnt + CNT_WIDTH'(1);
        if (cnt == CNT_WIDTH'(LAST_CNT)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
